// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
//   - ifuState_e   : fetch FSM state encoding (IDLE, REQ, HOLD, ERR)
//   - IFU_RESET_PC : default reset PC
//   - R_FORMAT/LW/SW/BEQ : main-control opcode values seen on op
//   - branchDisp() : sign-extended word offset converted to a byte displacement
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } ifuState_e;

  localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;

  localparam logic [5:0] R_FORMAT = 6'b000000;
  localparam logic [5:0] LW       = 6'b100011;
  localparam logic [5:0] SW       = 6'b101011;
  localparam logic [5:0] BEQ      = 6'b000100;

  // Word offset -> byte displacement: sign-extend to 30 bits, then shift left by 2.
  function automatic logic [31:0] branchDisp(input logic [15:0] offset);
    return {{14{offset[15]}}, offset, 2'b00};
  endfunction

endpackage

// File: rtl/ifu_next_pc.sv
// ifu_next_pc: next-PC arithmetic for the fetch unit (purely combinational).
// Ports:
//   pc           in  32  current fetch PC
//   irPc         in  32  address of the instruction being accepted
//   branchTaken  in   1  accepted instruction is a taken branch
//   branchOffset in  16  signed word offset of the branch
//   pcPlus4      out 32  pc + 4 (sequential successor)
//   acceptPc     out 32  PC to fetch after an accept (branch target or pc)
module ifu_next_pc
  import ifu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] irPc,
  input  logic        branchTaken,
  input  logic [15:0] branchOffset,
  output logic [31:0] pcPlus4,
  output logic [31:0] acceptPc
);

  logic [31:0] branchTarget_s;

  assign pcPlus4        = pc + 32'd4;
  // Target is relative to the branch's own successor, wrapping modulo 2^32.
  assign branchTarget_s = irPc + 32'd4 + branchDisp(branchOffset);

  // Select the post-accept fetch address.
  always_comb begin
    acceptPc = pc;
    if (branchTaken) begin
      acceptPc = branchTarget_s;
    end else begin
      acceptPc = pc;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding instruction fetcher with an instruction
// register handed to the decoder through a valid/ready handshake.
// Optional feature macro: IFU_PERF_CNT_EN adds fetch_count / stall_count.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   imem_req, imem_addr      instruction-memory read request / word-aligned address
//   imem_ack, imem_rdata     memory response (only honoured in REQ)
//   ir_valid, ir, op, ir_pc  instruction register, its opcode field and fetch address
//   dec_ready                decoder consumes ir this cycle when ir_valid is high
//   branch_taken, branch_offset  redirect applied on the accept edge only
//   fetch_err                sticky memory-timeout flag
//   fetch_count, stall_count (IFU_PERF_CNT_EN) accepted instrs / stalled cycles
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = IFU_RESET_PC,
  parameter int          ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ir_valid,
  output logic [31:0] ir,
  output logic [5:0]  op,
  output logic [31:0] ir_pc,
  input  logic        dec_ready,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  output logic        fetch_err
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  // Counter only needs to reach ACK_TIMEOUT-1; the timeout fires on that cycle.
  localparam int WAIT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  ifuState_e         state_r;
  logic [31:0]       pc_r;
  logic [WAIT_W-1:0] waitCnt_r;
  logic [31:0]       pcPlus4_s;
  logic [31:0]       acceptPc_s;

  assign op = ir[31:26];

  ifu_next_pc uNextPc (
    .pc           (pc_r),
    .irPc         (ir_pc),
    .branchTaken  (branch_taken),
    .branchOffset (branch_offset),
    .pcPlus4      (pcPlus4_s),
    .acceptPc     (acceptPc_s)
  );

  // Fetch FSM with registered memory-side and decoder-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      pc_r      <= RESET_PC;
      waitCnt_r <= WAIT_W'(0);
      ir        <= 32'h0000_0000;
      ir_pc     <= 32'h0000_0000;
      ir_valid  <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      fetch_err <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r   <= REQ;
          imem_req  <= 1'b1;
          imem_addr <= pc_r;
          waitCnt_r <= WAIT_W'(0);
        end
        REQ: begin
          if (imem_ack) begin
            ir        <= imem_rdata;
            ir_pc     <= pc_r;
            pc_r      <= pcPlus4_s;
            ir_valid  <= 1'b1;
            imem_req  <= 1'b0;
            waitCnt_r <= WAIT_W'(0);
            state_r   <= HOLD;
          end else if (waitCnt_r == WAIT_LAST) begin
            imem_req  <= 1'b0;
            fetch_err <= 1'b1;
            state_r   <= ERR;
          end else begin
            waitCnt_r <= waitCnt_r + WAIT_W'(1);
          end
        end
        HOLD: begin
          // branch_taken only matters here, on the accept edge.
          if (dec_ready) begin
            ir_valid  <= 1'b0;
            imem_req  <= 1'b1;
            imem_addr <= acceptPc_s;
            pc_r      <= acceptPc_s;
            waitCnt_r <= WAIT_W'(0);
            state_r   <= REQ;
          end else begin
            ir_valid  <= 1'b1;
          end
        end
        ERR: begin
          imem_req  <= 1'b0;
          ir_valid  <= 1'b0;
          fetch_err <= 1'b1;
        end
        default: begin
          imem_req  <= 1'b0;
          ir_valid  <= 1'b0;
          fetch_err <= 1'b1;
          state_r   <= ERR;
        end
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  // Accept and stall event counters, free-running and wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= 32'h0000_0000;
      stall_count <= 32'h0000_0000;
    end else begin
      if (ir_valid && dec_ready) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (ir_valid && !dec_ready) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed stimulus, scoreboard of expected
// accepted instructions checked by an independent monitor at each negedge.
module tb_instr_fetch_unit;
  import ifu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0000_0000;
  logic        ir_valid;
  logic [31:0] ir;
  logic [5:0]  op;
  logic [31:0] ir_pc;
  logic        dec_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_offset = 16'h0000;
  logic        fetch_err;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  logic ackEn = 1'b0;
  logic ackForce = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } expEntry_t;
  expEntry_t sbQ[$];

  instr_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .ir_valid      (ir_valid),
    .ir            (ir),
    .op            (op),
    .ir_pc         (ir_pc),
    .dec_ready     (dec_ready),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .fetch_err     (fetch_err)
`ifdef IFU_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count),
    .stall_count   (stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step until the instruction fetched from pc is held in ir (bounded).
  task automatic waitHold(input logic [31:0] pc, input int maxCyc, output int n);
    n = 0;
    while (!(ir_valid === 1'b1 && ir_pc === pc) && n < maxCyc) begin
      tick();
      n++;
    end
    vectors++;
    if (!(ir_valid === 1'b1 && ir_pc === pc)) begin
      miscompares++;
      $display("FAIL wait_hold: ir_pc %h valid %b, wanted pc %h within %0d cycles",
               ir_pc, ir_valid, pc, maxCyc);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h0000_0000: memWord = 32'h8C01_0004;  // lw
      32'h0000_0004: memWord = 32'h0022_1820;  // add
      32'h0000_0008: memWord = 32'hAC03_0008;  // sw
      32'h0000_000C: memWord = 32'h8C02_000C;  // lw
      32'h0000_0010: memWord = 32'h1000_FFFC;  // beq
      32'h0000_0020: memWord = 32'h0043_2020;  // add
      default:       memWord = 32'hDEAD_BEEF;
    endcase
  endfunction

  // Memory responder: zero-wait ack when enabled, or a forced stray ack.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      imem_ack   = ackForce || (ackEn && imem_req);
      imem_rdata = memWord(imem_addr);
    end
  end

  // Monitor: every accept is compared against the next scoreboard entry.
  initial begin
    expEntry_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ir_valid && dec_ready) begin
        if (sbQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_underflow: accepted ir %h at ir_pc %h with nothing expected", ir, ir_pc);
        end else begin
          e = sbQ.pop_front();
          check32("sb_ir", ir, e.word);
          check32("sb_ir_pc", ir_pc, e.pc);
          check32("sb_op", {26'd0, op}, {26'd0, e.word[31:26]});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    #12;
    check1("rst_imem_req", imem_req, 1'b0);
    check1("rst_ir_valid", ir_valid, 1'b0);
    check1("rst_fetch_err", fetch_err, 1'b0);
    check32("rst_imem_addr", imem_addr, 32'h0000_0000);
    check32("rst_ir", ir, 32'h0000_0000);
    check32("rst_ir_pc", ir_pc, 32'h0000_0000);
    ackEn = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // First edge: REQ at RESET_PC; second edge: ir valid
    tick();
    check1("first_req", imem_req, 1'b1);
    check32("first_addr", imem_addr, 32'h0000_0000);
    tick();
    check1("first_valid", ir_valid, 1'b1);
    check32("first_ir_pc", ir_pc, 32'h0000_0000);
    check32("first_ir", ir, 32'h8C01_0004);
    check32("first_op", {26'd0, op}, {26'd0, LW});

    // Stall for 5 cycles; a branch_taken without accept must be ignored
    branch_taken  = 1'b1;
    branch_offset = 16'h0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      check32("stall_ir", ir, 32'h8C01_0004);
      check32("stall_op", {26'd0, op}, {26'd0, 6'b100011});
      check1("stall_valid", ir_valid, 1'b1);
      check1("stall_no_req", imem_req, 1'b0);
    end
    branch_taken = 1'b0;

    sbQ.push_back({32'h8C01_0004, 32'h0000_0000});
    sbQ.push_back({32'h0022_1820, 32'h0000_0004});
    sbQ.push_back({32'hAC03_0008, 32'h0000_0008});
    sbQ.push_back({32'h8C02_000C, 32'h0000_000C});
    sbQ.push_back({32'h1000_FFFC, 32'h0000_0010});
    sbQ.push_back({32'h0022_1820, 32'h0000_0004});
    sbQ.push_back({32'hAC03_0008, 32'h0000_0008});
    sbQ.push_back({32'h8C02_000C, 32'h0000_000C});
    sbQ.push_back({32'h1000_FFFC, 32'h0000_0010});
    sbQ.push_back({32'h0043_2020, 32'h0000_0020});
    dec_ready = 1'b1;
    tick();
    check32("after_stall_addr", imem_addr, 32'h0000_0004);
    check1("after_stall_req", imem_req, 1'b1);

    // Throughput: one instruction per 2 cycles
    waitHold(32'h0000_0004, 4, n);
    waitHold(32'h0000_0008, 4, n);
    check32("throughput_cycles", n, 2);

    // Backward branch: 0x10 + 4 - 16 = 0x04
    waitHold(32'h0000_0010, 10, n);
    branch_taken  = 1'b1;
    branch_offset = 16'hFFFC;
    tick();
    branch_taken = 1'b0;
    check32("branch_back_addr", imem_addr, 32'h0000_0004);

    // Forward branch: 0x10 + 4 + 12 = 0x20
    waitHold(32'h0000_0010, 12, n);
    branch_taken  = 1'b1;
    branch_offset = 16'h0003;
    tick();
    branch_taken = 1'b0;
    check32("branch_fwd_addr", imem_addr, 32'h0000_0020);
    waitHold(32'h0000_0020, 4, n);

    // Timeout: no ack for 15 REQ cycles
    ackEn = 1'b0;
    tick();
    check32("timeout_addr", imem_addr, 32'h0000_0024);
    repeat (14) tick();
    check1("pre_timeout_err", fetch_err, 1'b0);
    check1("pre_timeout_req", imem_req, 1'b1);
    tick();
    check1("timeout_err", fetch_err, 1'b1);
    check1("timeout_req", imem_req, 1'b0);
    check1("timeout_valid", ir_valid, 1'b0);
    ackForce = 1'b1;
    repeat (3) tick();
    ackForce = 1'b0;
    check1("err_stray_ack_err", fetch_err, 1'b1);
    check1("err_stray_ack_req", imem_req, 1'b0);
    check1("err_stray_ack_valid", ir_valid, 1'b0);
    check32("err_stray_ack_addr", imem_addr, 32'h0000_0024);

    // Reset clears fetch_err
    dec_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check1("reset_clears_err", fetch_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset during a REQ wait drops imem_req without a clock edge
    tick();
    check1("wait_req", imem_req, 1'b1);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check1("async_req_drop", imem_req, 1'b0);
    check32("async_addr", imem_addr, 32'h0000_0000);
    ackEn = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check32("restart_addr", imem_addr, 32'h0000_0000);
    check1("restart_req", imem_req, 1'b1);
    tick();
    check1("restart_valid", ir_valid, 1'b1);

    // Reset mid-HOLD discards the held instruction
    #2;
    rst_n = 1'b0;
    #1;
    check1("hold_rst_valid", ir_valid, 1'b0);
    check32("hold_rst_ir", ir, 32'h0000_0000);
    check32("hold_rst_ir_pc", ir_pc, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Stall 4 cycles then accept 3 instructions
    waitHold(32'h0000_0000, 5, n);
    repeat (4) tick();
    sbQ.push_back({32'h8C01_0004, 32'h0000_0000});
    sbQ.push_back({32'h0022_1820, 32'h0000_0004});
    sbQ.push_back({32'hAC03_0008, 32'h0000_0008});
    dec_ready = 1'b1;
    repeat (5) tick();
    dec_ready = 1'b0;
    check32("final_addr", imem_addr, 32'h0000_000C);
`ifdef IFU_PERF_CNT_EN
    check32("fetch_count", fetch_count, 32'd3);
    check32("stall_count", stall_count, 32'd4);
`endif
    repeat (2) tick();
    check32("sb_empty", sbQ.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 The block SHALL have parameter ACK_TIMEOUT, default 15, meaning the maximum number of cycles spent waiting for imem_ack.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port imem_req, output, 1 bit: instruction-memory read request.
REQ-006 The block SHALL have port imem_addr, output, 32 bits: byte address of the fetch, always word-aligned.
REQ-007 The block SHALL have port imem_ack, input, 1 bit: imem_rdata is valid this cycle.
REQ-008 The block SHALL have port imem_rdata, input, 32 bits: fetched instruction word.
REQ-009 The block SHALL have port ir_valid, output, 1 bit: ir holds an instruction not yet consumed.
REQ-010 The block SHALL have port ir, output, 32 bits: instruction register.
REQ-011 The block SHALL have port op, output, 6 bits: ir[31:26], driving the main control unit opcode input.
REQ-012 The block SHALL have port ir_pc, output, 32 bits: address the ir word was fetched from.
REQ-013 The block SHALL have port dec_ready, input, 1 bit: downstream consumes ir this cycle when ir_valid is high.
REQ-014 The block SHALL have port branch_taken, input, 1 bit: the consumed instruction is a taken branch (Branch AND Zero).
REQ-015 The block SHALL have port branch_offset, input, 16 bits: signed word offset of the taken branch.
REQ-016 The block SHALL have port fetch_err, output, 1 bit: sticky timeout flag.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, HOLD and ERR.
REQ-018 IDLE SHALL move to REQ on the first clock edge after reset release.
REQ-019 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc.
REQ-020 In REQ, an imem_ack SHALL load ir from imem_rdata, load ir_pc from pc, set pc to pc+4 and move to HOLD; an ack in the first REQ cycle SHALL be accepted.
REQ-021 In HOLD, ir_valid SHALL be 1, imem_req 0, and ir/ir_pc SHALL remain stable until dec_ready.
REQ-022 In HOLD with dec_ready=1, the FSM SHALL move to REQ and clear ir_valid.
REQ-023 On that same accept edge, branch_taken=1 SHALL set pc to ir_pc + 4 + (sign_extend(branch_offset) << 2), modulo 2^32.
REQ-024 branch_taken SHALL be ignored whenever an accept (ir_valid AND dec_ready) is not occurring.
REQ-025 imem_ack outside REQ SHALL be ignored.
REQ-026 A wait counter SHALL count REQ cycles without ack and clear on entering REQ; reaching ACK_TIMEOUT with no ack SHALL move to ERR and set fetch_err.
REQ-027 ERR SHALL drive imem_req=0 and ir_valid=0 and SHALL be left only by reset.
REQ-028 Steady-state throughput with zero-wait memory and dec_ready held at 1 SHALL be one instruction per 2 cycles.

Reset
REQ-029 rst_n=0 SHALL immediately and asynchronously force: state IDLE, pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, imem_req=0, imem_addr=RESET_PC, fetch_err=0, wait counter=0.
REQ-030 A reset asserted mid-fetch or mid-HOLD SHALL discard the in-flight instruction without any partial update.

Configuration
REQ-031 With IFU_PERF_CNT_EN defined, the block SHALL add 32-bit outputs fetch_count (increments per accepted instruction) and stall_count (increments per cycle in which ir_valid=1 and dec_ready=0), both reset to 0 and wrapping.
REQ-032 Without IFU_PERF_CNT_EN, these ports and counters SHALL be absent.

Structure
REQ-033 Package ifu_pkg SHALL hold the FSM state enum, RESET_PC default and opcode constants R_FORMAT=6'b000000, LW=6'b100011, SW=6'b101011, BEQ=6'b000100.
REQ-034 Next-PC arithmetic (pc+4, branch target) SHALL be a sub-module ifu_next_pc.

Verification
REQ-035 Zero-wait memory, ack in every REQ cycle: first ir_valid appears 2 edges after reset release with ir_pc=0; the next instruction has ir_pc=4.
REQ-036 With ir=LW word 32'h8C01_0004 in HOLD and dec_ready=0 for 5 cycles: ir, op=6'b100011 and ir_valid are held stable; then dec_ready=1 causes the next imem_addr=4.
REQ-037 BEQ at ir_pc=0x10 accepted with branch_taken=1, offset=16'hFFFC: next imem_addr=0x04; with offset=16'h0003: next imem_addr=0x20.
REQ-038 No ack for 15 REQ cycles: fetch_err=1, state ERR, imem_req=0; a later imem_ack has no effect; reset then clears fetch_err.
REQ-039 rst_n pulsed low during a REQ wait: imem_req drops in the same cycle without a clock edge; fetch restarts at RESET_PC.
REQ-040 With IFU_PERF_CNT_EN defined, 3 accepts and 4 stall cycles yield fetch_count=3 and stall_count=4.
